// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage for the pipelined RV32I core.
// Owns the fetch PC, issues one-at-a-time requests to a variable-latency
// instruction memory, buffers a returned word while decode is stalled and
// handles execute-stage redirects, including killing an in-flight request.
//
// Ports:
//   clk         rising-edge clock
//   n_rst       asynchronous active-low reset
//   StallF      fetch/decode register not accepting this cycle
//   PCSrcE      redirect request from execute
//   PCTargetE   redirect target (bits [1:0] ignored)
//   imem_req    request strobe, accepted by memory the same cycle
//   imem_addr   request address (always the PC)
//   imem_ack    read data valid for the outstanding request
//   imem_rdata  instruction word, valid with imem_ack
//   RD          instruction to fetch/decode (NOP when InstrValidF=0)
//   PCF         address of the instruction on RD
//   PC_plus4F   PCF + 4, modulo 2^32
//   InstrValidF RD holds a real instruction this cycle
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] RD,
  output logic [31:0] PCF,
  output logic [31:0] PC_plus4F,
  output logic        InstrValidF
);

  localparam logic [31:0] NOP = 32'h0000_0033;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic        kill_q, kill_d;

  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        live_ack;

  assign target   = PCTargetE & ~32'd3;
  assign pc_plus4 = pc_q + 32'd4;
  // An ack is usable only for a request that was neither killed earlier nor
  // is being redirected away from in this very cycle.
  assign live_ack = (state_q == S_WAIT) && imem_ack && !kill_q && !PCSrcE;

  always_comb begin
    imem_req    = (state_q == S_REQ) && !PCSrcE;
    imem_addr   = pc_q;
    PCF         = pc_q;
    PC_plus4F   = pc_plus4;
    InstrValidF = 1'b0;
    RD          = NOP;
    if (live_ack) begin
      InstrValidF = 1'b1;
      RD          = imem_rdata;
    end else if ((state_q == S_HOLD) && !PCSrcE) begin
      InstrValidF = 1'b1;
      RD          = buf_q;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    kill_d  = kill_q;
    unique case (state_q)
      S_REQ: begin
        if (PCSrcE) begin
          pc_d = target;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!imem_ack) begin
          if (PCSrcE) begin
            pc_d   = target;
            kill_d = 1'b1;
          end
        end else if (kill_q || PCSrcE) begin
          kill_d  = 1'b0;
          state_d = S_REQ;
          if (PCSrcE) pc_d = target;
        end else if (!StallF) begin
          pc_d    = pc_plus4;
          state_d = S_REQ;
        end else begin
          buf_d   = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (!StallF) begin
          pc_d    = pc_plus4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      kill_q  <= kill_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized testbench for fetch_unit against a transaction-level model of
// the fetch stream: a memory with random latency, a program-order PC and a
// pending-word slot for stalled deliveries.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        StallF = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] RD;
  logic [31:0] PCF;
  logic [31:0] PC_plus4F;
  logic        InstrValidF;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .StallF     (StallF),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .RD         (RD),
    .PCF        (PCF),
    .PC_plus4F  (PC_plus4F),
    .InstrValidF(InstrValidF)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom % 6)
      0:       return 32'hFFFF_FFFC;
      1:       return 32'h0000_0400;
      2:       return 32'h0000_0800;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Model state
  bit          outst, okill, pend;
  logic [31:0] oaddr, pdata, exp_pc;
  int unsigned lat;

  task automatic reset_model();
    outst  = 0;
    okill  = 0;
    pend   = 0;
    exp_pc = RST_PC;
    lat    = 0;
    oaddr  = '0;
    pdata  = '0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_pcf"},   PCF, RST_PC);
    check_eq({tag, "_pcp4"},  PC_plus4F, RST_PC + 32'd4);
    check_eq({tag, "_addr"},  imem_addr, RST_PC);
    check_eq({tag, "_req"},   {31'b0, imem_req}, 32'd1);
    check_eq({tag, "_valid"}, {31'b0, InstrValidF}, 32'd0);
    check_eq({tag, "_rd"},    RD, NOP);
  endtask

  // One cycle: drive inputs just after the falling edge, check outputs
  // against the model, then advance the model across the next rising edge.
  task automatic do_cycle(input int unsigned redir_pct, input int unsigned stall_pct);
    bit          live, exp_valid, exp_req;
    logic [31:0] exp_rd;
    PCSrcE    = ($urandom % 100) < redir_pct;
    PCTargetE = pick_target();
    StallF    = ($urandom % 100) < stall_pct;
    if (outst) begin
      imem_ack   = (lat == 1);
      imem_rdata = imem_ack ? memword(oaddr) : $urandom;
    end else begin
      imem_ack   = ($urandom % 6) == 0;  // spurious ack, must be ignored
      imem_rdata = $urandom;
    end
    #1;
    live      = outst && imem_ack && !okill && !PCSrcE;
    exp_valid = !PCSrcE && (live || pend);
    exp_rd    = !exp_valid ? NOP : (pend ? pdata : memword(oaddr));
    exp_req   = !PCSrcE && !outst && !pend;
    check_eq("req",   {31'b0, imem_req}, {31'b0, exp_req});
    check_eq("addr",  imem_addr, exp_pc);
    check_eq("pcf",   PCF, exp_pc);
    check_eq("pcp4",  PC_plus4F, exp_pc + 32'd4);
    check_eq("valid", {31'b0, InstrValidF}, {31'b0, exp_valid});
    check_eq("rd",    RD, exp_rd);

    if (PCSrcE) begin
      pend   = 0;
      exp_pc = PCTargetE & ~32'd3;
      if (outst) begin
        if (imem_ack) begin
          outst = 0;
          okill = 0;
        end else begin
          okill = 1;
          lat--;
        end
      end
    end else if (!outst && !pend) begin
      outst = 1;
      okill = 0;
      oaddr = exp_pc;
      lat   = $urandom_range(1, 4);
    end else if (outst && imem_ack) begin
      outst = 0;
      if (okill) okill = 0;
      else if (!StallF) exp_pc = exp_pc + 32'd4;
      else begin
        pend  = 1;
        pdata = memword(oaddr);
      end
    end else if (outst) begin
      lat--;
    end else if (pend && !StallF) begin
      pend   = 0;
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  initial begin
    reset_model();
    #12;
    check_reset("rst");
    @(negedge clk);
    check_reset("rst_hold");
    @(negedge clk);
    n_rst = 1'b1;
    do_cycle(0, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      do_cycle(0, 0);
    end
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      do_cycle(12, 50);
    end
    // Reset while a request is outstanding.
    for (int i = 0; i < 50 && !(outst && lat > 1); i++) begin
      @(negedge clk);
      do_cycle(5, 30);
    end
    check_eq("wait_reached", {31'b0, outst}, 32'd1);
    @(negedge clk);
    PCSrcE   = 1'b0;
    StallF   = 1'b0;
    imem_ack = 1'b0;
    n_rst    = 1'b0;
    #1;
    check_reset("midrst");
    @(posedge clk);
    #1;
    check_reset("midrst_hold");
    reset_model();
    @(negedge clk);
    n_rst = 1'b1;
    do_cycle(0, 0);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      do_cycle(12, 50);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
